exu_mul_arb: RTL and testbench

EXU_MUL_ARB -- requirements
Module: exu_mul_arb

---
 rtl/exu_mul_arb_if.sv | 60 ++++++
 rtl/exu_mul_arb.sv | 126 ++++++++++++
 tb/tb_exu_mul_arb.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/exu_mul_arb_if.sv
// Bundle of the exu_mul_arb request, response and multiplier-side signals.
// The slave modport is the arbiter's view; master is the environment's view.
interface exu_mul_arb_if;
  // Requester 0
  logic        p0_valid_i;
  logic        p0_ready_o;
  logic [31:0] p0_op1_i;
  logic [31:0] p0_op2_i;
  logic [3:0]  p0_op_i;
  logic [4:0]  p0_waddr_i;
  logic        p0_kill_i;
  // Requester 1
  logic        p1_valid_i;
  logic        p1_ready_o;
  logic [31:0] p1_op1_i;
  logic [31:0] p1_op2_i;
  logic [3:0]  p1_op_i;
  logic [4:0]  p1_waddr_i;
  logic        p1_kill_i;
  // Response channel
  logic        resp_valid_o;
  logic        resp_id_o;
  logic [31:0] resp_data_o;
  logic [4:0]  resp_waddr_o;
  logic        resp_ready_i;
  // Multiplier side
  logic        mul_start_o;
  logic [31:0] mul_op1_o;
  logic [31:0] mul_op2_o;
  logic [3:0]  mul_op_o;
  logic [4:0]  mul_waddr_o;
  logic        mul_ready_i;
  logic [31:0] mul_result_i;
  // Status
  logic        busy_o;

  modport slave (
    input  p0_valid_i, p0_op1_i, p0_op2_i, p0_op_i, p0_waddr_i, p0_kill_i,
    output p0_ready_o,
    input  p1_valid_i, p1_op1_i, p1_op2_i, p1_op_i, p1_waddr_i, p1_kill_i,
    output p1_ready_o,
    output resp_valid_o, resp_id_o, resp_data_o, resp_waddr_o,
    input  resp_ready_i,
    output mul_start_o, mul_op1_o, mul_op2_o, mul_op_o, mul_waddr_o,
    input  mul_ready_i, mul_result_i,
    output busy_o
  );

  modport master (
    output p0_valid_i, p0_op1_i, p0_op2_i, p0_op_i, p0_waddr_i, p0_kill_i,
    input  p0_ready_o,
    output p1_valid_i, p1_op1_i, p1_op2_i, p1_op_i, p1_waddr_i, p1_kill_i,
    input  p1_ready_o,
    input  resp_valid_o, resp_id_o, resp_data_o, resp_waddr_o,
    output resp_ready_i,
    input  mul_start_o, mul_op1_o, mul_op2_o, mul_op_o, mul_waddr_o,
    output mul_ready_i, mul_result_i,
    input  busy_o
  );
endinterface

// File: rtl/exu_mul_arb.sv
// exu_mul_arb: two-port arbiter in front of a shared iterative multiplier.
// One operation in flight at a time: IDLE (accept) -> BUSY (multiplier runs)
// -> RESP (result held until consumed). Either owner kill aborts the operation.
// Optional feature macro MUL_ARB_RR_EN: round-robin between simultaneous
// requesters; when undefined, port 0 has fixed priority.
module exu_mul_arb (
  input  logic             clk,
  input  logic             rst,
  exu_mul_arb_if.slave     bus
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state_q, state_d;
  logic        owner_q;
  logic [31:0] op1_q;
  logic [31:0] op2_q;
  logic [3:0]  op_q;
  logic [4:0]  waddr_q;
  logic [31:0] data_q;

  logic req0, req1;
  logic gnt0, gnt1;
  logic owner_kill;
  logic capture;

  // A killed request is never eligible for grant.
  assign req0       = bus.p0_valid_i & ~bus.p0_kill_i;
  assign req1       = bus.p1_valid_i & ~bus.p1_kill_i;
  assign owner_kill = owner_q ? bus.p1_kill_i : bus.p0_kill_i;

`ifdef MUL_ARB_RR_EN
  // Last-granted port; resets to 1 so the first contested grant goes to port 0.
  logic last_q;

  // Pick the requester; on a tie favour the port that was not granted last.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == IDLE && !rst) begin
      if (req0 && req1) begin
        gnt0 = last_q;
        gnt1 = ~last_q;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  // Pointer follows every grant.
  always_ff @(posedge clk) begin
    if (rst)              last_q <= 1'b1;
    else if (gnt0 | gnt1) last_q <= gnt1;
  end
`else
  // Fixed priority: port 0 always wins a tie.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == IDLE && !rst) begin
      gnt0 = req0;
      gnt1 = req1 & ~req0;
    end
  end
`endif

  // Result is captured only if the owner is not flushing in the same cycle.
  assign capture = (state_q == BUSY) & bus.mul_ready_i & ~owner_kill;

  // Next-state logic; owner kill dominates multiplier completion and response.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (gnt0 | gnt1) state_d = BUSY;
      BUSY: begin
        if (owner_kill)            state_d = IDLE;
        else if (bus.mul_ready_i)  state_d = RESP;
      end
      RESP: if (owner_kill || bus.resp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, operand latch on grant and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      op1_q   <= '0;
      op2_q   <= '0;
      op_q    <= '0;
      waddr_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (gnt0 | gnt1) begin
        owner_q <= gnt1;
        op1_q   <= gnt1 ? bus.p1_op1_i   : bus.p0_op1_i;
        op2_q   <= gnt1 ? bus.p1_op2_i   : bus.p0_op2_i;
        op_q    <= gnt1 ? bus.p1_op_i    : bus.p0_op_i;
        waddr_q <= gnt1 ? bus.p1_waddr_i : bus.p0_waddr_i;
      end
      if (capture) data_q <= bus.mul_result_i;
    end
  end

  // Start is held through the whole operation and drops in the ready cycle
  // (or on owner kill) so the multiplier never relaunches.
  assign bus.mul_start_o  = (state_q == BUSY) & ~bus.mul_ready_i & ~owner_kill;
  assign bus.mul_op1_o    = op1_q;
  assign bus.mul_op2_o    = op2_q;
  assign bus.mul_op_o     = op_q;
  assign bus.mul_waddr_o  = waddr_q;

  assign bus.p0_ready_o   = gnt0;
  assign bus.p1_ready_o   = gnt1;

  assign bus.resp_valid_o = (state_q == RESP);
  assign bus.resp_id_o    = owner_q;
  assign bus.resp_data_o  = data_q;
  assign bus.resp_waddr_o = waddr_q;

  assign bus.busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_exu_mul_arb.sv
// Self-checking bench for exu_mul_arb with a behavioural iterative multiplier.
module tb_exu_mul_arb;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  exu_mul_arb_if bus ();

  exu_mul_arb dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  localparam logic [3:0] OP_MUL    = 4'b0001;
  localparam logic [3:0] OP_MULH   = 4'b0010;
  localparam logic [3:0] OP_MULHSU = 4'b0100;
  localparam logic [3:0] OP_MULHU  = 4'b1000;

`ifdef MUL_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  // Reference arithmetic for the four RISC-V multiply flavours.
  function automatic logic [31:0] mul_ref(input logic [3:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = {32'b0, a};
    eb = {32'b0, b};
    if (op == OP_MULH || op == OP_MULHSU) ea = {{32{a[31]}}, a};
    if (op == OP_MULH)                    eb = {{32{b[31]}}, b};
    p = ea * eb;
    return (op == OP_MUL) ? p[31:0] : p[63:32];
  endfunction

  // Behavioural multiplier: start sampled, 16 iterations, output stage,
  // then a one-cycle ready pulse; abandons the job when start drops.
  int   mcnt;
  logic mrdy;
  always @(posedge clk) begin
    if (rst || !bus.mul_start_o) begin
      mcnt <= 0;
      mrdy <= 1'b0;
    end else begin
      mcnt <= mcnt + 1;
      mrdy <= (mcnt == 17);
    end
  end
  assign bus.mul_ready_i  = mrdy;
  assign bus.mul_result_i = mul_ref(bus.mul_op_o, bus.mul_op1_o, bus.mul_op2_o);

  typedef struct {
    logic        id;
    logic [31:0] data;
    logic [4:0]  waddr;
  } exp_t;

  exp_t sb_q[$];
  exp_t last_exp;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Wait for the arbiter to accept, confirm the granted port, push the
  // expected response, then move into the first BUSY cycle.
  task automatic accept(input bit exp_port);
    bit   got;
    exp_t e;
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (bus.p0_ready_o || bus.p1_ready_o) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    if (!got) begin
      check("accept_timeout", 64'd0, 64'd1);
      return;
    end
    check("grant", {62'd0, bus.p1_ready_o, bus.p0_ready_o}, exp_port ? 64'd2 : 64'd1);
    e.id    = exp_port;
    e.data  = exp_port ? mul_ref(bus.p1_op_i, bus.p1_op1_i, bus.p1_op2_i)
                       : mul_ref(bus.p0_op_i, bus.p0_op1_i, bus.p0_op2_i);
    e.waddr = exp_port ? bus.p1_waddr_i : bus.p0_waddr_i;
    sb_q.push_back(e);
    tick();
    bus.p0_valid_i = 1'b0;
    bus.p1_valid_i = 1'b0;
  endtask

  // Called in the first BUSY cycle; expects resp_valid_o 20 cycles after accept.
  task automatic wait_resp();
    int cyc;
    bit got;
    cyc = 1;
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      #1;
      if (bus.resp_valid_o) begin
        got = 1'b1;
        break;
      end
      tick();
      cyc++;
    end
    if (!got) begin
      check("resp_timeout", 64'd0, 64'd1);
      return;
    end
    check("latency", cyc, 64'd20);
    if (sb_q.size() == 0) begin
      check("sb_empty", 64'd0, 64'd1);
      return;
    end
    last_exp = sb_q.pop_front();
    check("resp_id",    {63'd0, bus.resp_id_o},    {63'd0, last_exp.id});
    check("resp_data",  {32'd0, bus.resp_data_o},  {32'd0, last_exp.data});
    check("resp_waddr", {59'd0, bus.resp_waddr_o}, {59'd0, last_exp.waddr});
    if (bus.resp_ready_i) tick();
  endtask

  task automatic set_p0(input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] wa);
    bus.p0_op_i = op; bus.p0_op1_i = a; bus.p0_op2_i = b; bus.p0_waddr_i = wa;
  endtask

  task automatic set_p1(input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] wa);
    bus.p1_op_i = op; bus.p1_op1_i = a; bus.p1_op2_i = b; bus.p1_waddr_i = wa;
  endtask

  initial begin
    bit seen;
    rst = 1'b1;
    bus.p0_valid_i = 1'b0; bus.p0_kill_i = 1'b0;
    bus.p1_valid_i = 1'b0; bus.p1_kill_i = 1'b0;
    set_p0(4'd0, 32'd0, 32'd0, 5'd0);
    set_p1(4'd0, 32'd0, 32'd0, 5'd0);
    bus.resp_ready_i = 1'b1;
    repeat (3) tick();

    // Reset state, with a pending request that must not be granted.
    bus.p0_valid_i = 1'b1;
    #1;
    check("rst_p0_ready",   {63'd0, bus.p0_ready_o},   64'd0);
    check("rst_resp_valid", {63'd0, bus.resp_valid_o}, 64'd0);
    check("rst_mul_start",  {63'd0, bus.mul_start_o},  64'd0);
    check("rst_busy",       {63'd0, bus.busy_o},       64'd0);
    check("rst_mul_op1",    {32'd0, bus.mul_op1_o},    64'd0);
    check("rst_resp_data",  {32'd0, bus.resp_data_o},  64'd0);
    bus.p0_valid_i = 1'b0;
    tick();
    rst = 1'b0;

    // p0 MUL 7x6 -> 42
    set_p0(OP_MUL, 32'd7, 32'd6, 5'd3);
    bus.p0_valid_i = 1'b1;
    accept(1'b0);
    check("busy_in_op", {63'd0, bus.busy_o}, 64'd1);
    wait_resp();

    // p1 MULHU and MULH
    set_p1(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9);
    bus.p1_valid_i = 1'b1;
    accept(1'b1);
    wait_resp();
    set_p1(OP_MULH, 32'hFFFF_FFFF, 32'h0000_0002, 5'd10);
    bus.p1_valid_i = 1'b1;
    accept(1'b1);
    wait_resp();
    set_p1(OP_MULHSU, 32'h8000_0000, 32'h0000_0003, 5'd11);
    bus.p1_valid_i = 1'b1;
    accept(1'b1);
    wait_resp();

    // Simultaneous requests twice in a row
    set_p0(OP_MUL, 32'd100, 32'd5, 5'd1);
    set_p1(OP_MUL, 32'd200, 32'd3, 5'd2);
    bus.p0_valid_i = 1'b1; bus.p1_valid_i = 1'b1;
    accept(1'b0);
    wait_resp();
    bus.p0_valid_i = 1'b1; bus.p1_valid_i = 1'b1;
    accept(RR ? 1'b1 : 1'b0);
    wait_resp();

    // Owner kill at cycle 8 of p0's operation; non-owner kill is ignored
    set_p0(OP_MUL, 32'd11, 32'd13, 5'd4);
    bus.p0_valid_i = 1'b1;
    accept(1'b0);
    repeat (4) tick();
    bus.p1_kill_i = 1'b1;
    #1;
    check("nonowner_kill_start", {63'd0, bus.mul_start_o}, 64'd1);
    tick();
    bus.p1_kill_i = 1'b0;
    repeat (2) tick();
    bus.p0_kill_i = 1'b1;
    #1;
    check("kill_start", {63'd0, bus.mul_start_o}, 64'd0);
    tick();
    bus.p0_kill_i = 1'b0;
    #1;
    check("kill_idle", {63'd0, bus.busy_o}, 64'd0);
    void'(sb_q.pop_back());
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      tick();
      #1;
      if (bus.resp_valid_o) seen = 1'b1;
    end
    check("kill_no_resp", {63'd0, seen}, 64'd0);
    set_p1(OP_MUL, 32'd9, 32'd9, 5'd5);
    bus.p1_valid_i = 1'b1;
    accept(1'b1);
    wait_resp();

    // Back-pressure in RESP: outputs hold, p1 not accepted
    bus.resp_ready_i = 1'b0;
    set_p0(OP_MUL, 32'd123, 32'd1000, 5'd6);
    bus.p0_valid_i = 1'b1;
    accept(1'b0);
    wait_resp();
    set_p1(OP_MULHU, 32'h1234_5678, 32'h9ABC_DEF0, 5'd7);
    bus.p1_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      #1;
      check("hold_valid", {63'd0, bus.resp_valid_o}, 64'd1);
      check("hold_data",  {32'd0, bus.resp_data_o},  {32'd0, last_exp.data});
      check("hold_p1_rdy", {63'd0, bus.p1_ready_o},  64'd0);
    end
    bus.resp_ready_i = 1'b1;
    #1;
    check("release_p1_rdy", {63'd0, bus.p1_ready_o}, 64'd0);
    tick();
    accept(1'b1);
    wait_resp();

    // Reset at cycle 10 of an operation
    set_p0(OP_MUL, 32'd77, 32'd3, 5'd8);
    bus.p0_valid_i = 1'b1;
    accept(1'b0);
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("mrst_busy",       {63'd0, bus.busy_o},       64'd0);
    check("mrst_mul_start",  {63'd0, bus.mul_start_o},  64'd0);
    check("mrst_resp_valid", {63'd0, bus.resp_valid_o}, 64'd0);
    check("mrst_mul_op1",    {32'd0, bus.mul_op1_o},    64'd0);
    check("mrst_resp_data",  {32'd0, bus.resp_data_o},  64'd0);
    void'(sb_q.pop_back());
    set_p1(OP_MUL, 32'd21, 32'd2, 5'd12);
    bus.p1_valid_i = 1'b1;
    accept(1'b1);
    wait_resp();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
